// File: rtl/axi4_burst_traffic_checker.sv
// AXI4 burst traffic checker: writes NUM_BURSTS incrementing-pattern bursts, reads
// each one back and counts response, data and rlast errors into a saturating counter.
//
// state  | meaning
// IDLE   | waiting for start
// AW     | write address offered
// W      | write beats issued, one per wready
// B      | waiting for write response
// AR     | read address offered
// R      | read beats compared against the pattern
// NEXT   | advance burst index, address and pattern base
// DONE   | results held (done/pass/err_cnt) until next start
module axi4_burst_traffic_checker #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter int                BURST_LEN  = 8,
    parameter int                NUM_BURSTS = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [15:0]         err_cnt,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [7:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [7:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast,
    input  logic                m_rvalid,
    output logic                m_rready
);
    localparam int                STRB_W     = DATA_W / 8;
    localparam logic [2:0]        AXSIZE     = 3'($clog2(STRB_W));
    localparam logic [7:0]        AXLEN      = 8'(BURST_LEN - 1);
    localparam logic [8:0]        LAST_BEAT  = 9'(BURST_LEN - 1);
    localparam logic [15:0]       LAST_BURST = 16'(NUM_BURSTS - 1);
    localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(BURST_LEN * STRB_W);
    localparam logic [31:0]       BL32       = 32'(BURST_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_NEXT, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       burst_q;
    logic [8:0]        beat_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       base_q;
    logic [15:0]       err_q, err_d;
    logic              done_q, pass_q, settle_q;
    logic              launch, last_beat;
    logic [31:0]       pat32;
    logic [DATA_W-1:0] pattern;
    logic [1:0]        rd_errs, err_inc;
    logic [16:0]       err_sum;

    // settle_q blocks start for the first cycle after reset release
    assign launch    = start && !settle_q && (state_q == S_IDLE || state_q == S_DONE);
    assign last_beat = (beat_q == LAST_BEAT);
    assign pat32     = base_q + {23'd0, beat_q} + 32'd1;
    assign pattern   = DATA_W'(pat32);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        case (state_q)
            S_IDLE: if (launch) state_d = S_AW;
            S_AW: begin
                m_awvalid = 1'b1;
                if (m_awready) state_d = S_W;
            end
            S_W: begin
                m_wvalid = 1'b1;
                if (m_wready && last_beat) state_d = S_B;
            end
            S_B: begin
                m_bready = 1'b1;
                if (m_bvalid) state_d = S_AR;
            end
            S_AR: begin
                m_arvalid = 1'b1;
                if (m_arready) state_d = S_R;
            end
            S_R: begin
                m_rready = 1'b1;
                if (m_rvalid && last_beat) state_d = S_NEXT;
            end
            S_NEXT: state_d = (burst_q == LAST_BURST) ? S_DONE : S_AW;
            S_DONE: if (launch) state_d = S_AW;
            default: state_d = S_IDLE;
        endcase
    end

    // Payload is gated by state so everything reads zero outside its phase and in reset
    always_comb begin
        m_awaddr  = m_awvalid ? addr_q : '0;
        m_awlen   = m_awvalid ? AXLEN : 8'd0;
        m_awsize  = m_awvalid ? AXSIZE : 3'd0;
        m_awburst = m_awvalid ? 2'b01 : 2'b00;
        m_wdata   = m_wvalid ? pattern : '0;
        m_wstrb   = m_wvalid ? '1 : '0;
        m_wlast   = m_wvalid && last_beat;
        m_araddr  = m_arvalid ? addr_q : '0;
        m_arlen   = m_arvalid ? AXLEN : 8'd0;
        m_arsize  = m_arvalid ? AXSIZE : 3'd0;
        m_arburst = m_arvalid ? 2'b01 : 2'b00;
    end

    always_comb begin
        rd_errs = 2'd0;
        if (m_rdata != pattern)      rd_errs = rd_errs + 2'd1;
        if (m_rresp != 2'b00)        rd_errs = rd_errs + 2'd1;
        if (m_rlast != last_beat)    rd_errs = rd_errs + 2'd1;
        err_inc = 2'd0;
        if (state_q == S_B && m_bvalid && m_bresp != 2'b00) err_inc = 2'd1;
        if (state_q == S_R && m_rvalid)                     err_inc = rd_errs;
        err_sum = {1'b0, err_q} + {15'd0, err_inc};
        err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            burst_q  <= 16'd0;
            beat_q   <= 9'd0;
            addr_q   <= '0;
            base_q   <= 32'd0;
            err_q    <= 16'd0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            settle_q <= 1'b1;
        end else begin
            settle_q <= 1'b0;
            if (launch) begin
                burst_q <= 16'd0;
                beat_q  <= 9'd0;
                addr_q  <= BASE_ADDR;
                base_q  <= 32'd0;
                err_q   <= 16'd0;
                done_q  <= 1'b0;
                pass_q  <= 1'b0;
            end else begin
                err_q <= err_d;
                if ((state_q == S_W && m_wready) || (state_q == S_R && m_rvalid))
                    beat_q <= last_beat ? 9'd0 : beat_q + 9'd1;
                if (state_q == S_NEXT) begin
                    if (burst_q == LAST_BURST) begin
                        done_q <= 1'b1;
                        pass_q <= (err_q == 16'd0);
                    end else begin
                        burst_q <= burst_q + 16'd1;
                        addr_q  <= addr_q + STRIDE;
                        base_q  <= base_q + BL32;
                    end
                end
            end
        end
    end

    assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_q;

endmodule

// File: tb/tb_axi4_burst_traffic_checker.sv
// Scoreboard bench: reactive AXI memory slaves check every address/data handshake
// against expectations queued when each run is started.
module tb_axi4_burst_traffic_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- DUT 0: defaults ----------------
    logic        start0 = 1'b0;
    logic        busy0, done0, pass0;
    logic [15:0] err0;
    logic [31:0] awaddr0, araddr0, wdata0, rdata0;
    logic [7:0]  awlen0, arlen0;
    logic [2:0]  awsize0, arsize0;
    logic [1:0]  awburst0, arburst0, bresp0, rresp0;
    logic [3:0]  wstrb0;
    logic awvalid0, awready0, wlast0, wvalid0, wready0, bvalid0, bready0;
    logic arvalid0, arready0, rlast0, rvalid0, rready0;

    axi4_burst_traffic_checker dut0 (
        .ACLK(clk), .ARESET(rst), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0),
        .m_awaddr(awaddr0), .m_awlen(awlen0), .m_awsize(awsize0), .m_awburst(awburst0),
        .m_awvalid(awvalid0), .m_awready(awready0),
        .m_wdata(wdata0), .m_wstrb(wstrb0), .m_wlast(wlast0), .m_wvalid(wvalid0), .m_wready(wready0),
        .m_bresp(bresp0), .m_bvalid(bvalid0), .m_bready(bready0),
        .m_araddr(araddr0), .m_arlen(arlen0), .m_arsize(arsize0), .m_arburst(arburst0),
        .m_arvalid(arvalid0), .m_arready(arready0),
        .m_rdata(rdata0), .m_rresp(rresp0), .m_rlast(rlast0), .m_rvalid(rvalid0), .m_rready(rready0)
    );

    // ---------------- DUT 1: 64-bit, single-beat bursts, wrapping base ----------------
    logic        start1 = 1'b0;
    logic        busy1, done1, pass1;
    logic [15:0] err1;
    logic [31:0] awaddr1, araddr1;
    logic [63:0] wdata1, rdata1;
    logic [7:0]  awlen1, arlen1;
    logic [2:0]  awsize1, arsize1;
    logic [1:0]  awburst1, arburst1, bresp1, rresp1;
    logic [7:0]  wstrb1;
    logic awvalid1, awready1, wlast1, wvalid1, wready1, bvalid1, bready1;
    logic arvalid1, arready1, rlast1, rvalid1, rready1;

    axi4_burst_traffic_checker #(
        .DATA_W(64), .ADDR_W(32), .BURST_LEN(1), .NUM_BURSTS(2), .BASE_ADDR(32'hFFFF_FFF8)
    ) dut1 (
        .ACLK(clk), .ARESET(rst), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1),
        .m_awaddr(awaddr1), .m_awlen(awlen1), .m_awsize(awsize1), .m_awburst(awburst1),
        .m_awvalid(awvalid1), .m_awready(awready1),
        .m_wdata(wdata1), .m_wstrb(wstrb1), .m_wlast(wlast1), .m_wvalid(wvalid1), .m_wready(wready1),
        .m_bresp(bresp1), .m_bvalid(bvalid1), .m_bready(bready1),
        .m_araddr(araddr1), .m_arlen(arlen1), .m_arsize(arsize1), .m_arburst(arburst1),
        .m_arvalid(arvalid1), .m_arready(arready1),
        .m_rdata(rdata1), .m_rresp(rresp1), .m_rlast(rlast1), .m_rvalid(rvalid1), .m_rready(rready1)
    );

    // ---------------- slave 0 ----------------
    logic        bp0 = 1'b0, corrupt0 = 1'b0, berr0 = 1'b0;
    logic [31:0] mem0 [bit [31:0]];
    logic [31:0] exp_aw0[$], exp_ar0[$], exp_w0[$];
    int          aw_cnt0 = 0, ar_cnt0 = 0, wbeat0 = 0, rbeat0 = 0, rleft0 = 0;
    logic [31:0] waddr0 = 0, raddr0 = 0, hold_aw0 = 0, hold_w0 = 0, hold_ar0 = 0;
    logic        bpend0 = 0, rv0 = 0, stall_aw0 = 0, stall_w0 = 0, stall_ar0 = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                {awready0, wready0, bvalid0, arready0, rvalid0, rlast0} = '0;
                bresp0 = 2'b00; rresp0 = 2'b00; rdata0 = '0;
                wbeat0 = 0; rleft0 = 0; bpend0 = 0; rv0 = 0;
                stall_aw0 = 0; stall_w0 = 0; stall_ar0 = 0;
            end else begin
                if (stall_aw0) check_val("aw_hold", {awvalid0, awaddr0}, {1'b1, hold_aw0});
                if (stall_w0)  check_val("w_hold", {wvalid0, wdata0}, {1'b1, hold_w0});
                if (stall_ar0) check_val("ar_hold", {arvalid0, araddr0}, {1'b1, hold_ar0});
                awready0 = bp0 ? 1'($urandom_range(0, 1)) : 1'b1;
                wready0  = bp0 ? 1'($urandom_range(0, 1)) : 1'b1;
                arready0 = bp0 ? 1'($urandom_range(0, 1)) : 1'b1;
                bvalid0  = bpend0;
                bresp0   = berr0 ? 2'b10 : 2'b00;
                if (!rv0 && rleft0 > 0 && (!bp0 || $urandom_range(0, 1) == 1)) rv0 = 1'b1;
                rvalid0 = rv0;
                rdata0  = rv0 ? mem0[raddr0 + 32'(rbeat0 * 4)] : '0;
                if (rv0 && corrupt0 && ar_cnt0 == 2 && rbeat0 == 3) rdata0 = rdata0 ^ 32'h0000_00A5;
                rlast0 = rv0 && (rleft0 == 1);
                stall_aw0 = awvalid0 && !awready0; hold_aw0 = awaddr0;
                stall_w0  = wvalid0 && !wready0;   hold_w0  = wdata0;
                stall_ar0 = arvalid0 && !arready0; hold_ar0 = araddr0;
                if (awvalid0 && awready0) begin
                    if (exp_aw0.size() == 0) check_val("aw_extra", 1, 0);
                    else check_val("awaddr", awaddr0, exp_aw0.pop_front());
                    check_val("aw_ctl", {awlen0, awsize0, awburst0}, {8'd7, 3'd2, 2'd1});
                    waddr0 = awaddr0; wbeat0 = 0; aw_cnt0++;
                end
                if (wvalid0 && wready0) begin
                    if (exp_w0.size() == 0) check_val("w_extra", 1, 0);
                    else check_val("wdata", wdata0, exp_w0.pop_front());
                    check_val("w_last_strb", {wlast0, wstrb0}, {wbeat0 == 7, 4'hF});
                    mem0[waddr0 + 32'(wbeat0 * 4)] = wdata0;
                    if (wbeat0 == 7) bpend0 = 1'b1;
                    wbeat0++;
                end
                if (bvalid0 && bready0) bpend0 = 1'b0;
                if (arvalid0 && arready0) begin
                    if (exp_ar0.size() == 0) check_val("ar_extra", 1, 0);
                    else check_val("araddr", araddr0, exp_ar0.pop_front());
                    check_val("ar_ctl", {arlen0, arsize0, arburst0}, {8'd7, 3'd2, 2'd1});
                    raddr0 = araddr0; rleft0 = 8; rbeat0 = 0; ar_cnt0++;
                end
                if (rv0 && rready0) begin
                    rbeat0++; rleft0--; rv0 = 1'b0;
                end
            end
        end
    end

    // ---------------- slave 1 (always random back-pressure) ----------------
    logic [63:0] mem1 [bit [31:0]];
    logic [31:0] exp_aw1[$], exp_ar1[$];
    logic [63:0] exp_w1[$];
    int          rleft1 = 0;
    logic [31:0] raddr1 = 0, waddr1 = 0, hold_aw1 = 0, hold_ar1 = 0;
    logic [63:0] hold_w1 = 0;
    logic        bpend1 = 0, rv1 = 0, stall_aw1 = 0, stall_w1 = 0, stall_ar1 = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                {awready1, wready1, bvalid1, arready1, rvalid1, rlast1} = '0;
                bresp1 = 2'b00; rresp1 = 2'b00; rdata1 = '0;
                rleft1 = 0; bpend1 = 0; rv1 = 0; stall_aw1 = 0; stall_w1 = 0; stall_ar1 = 0;
            end else begin
                if (stall_aw1) check_val("aw_hold1", {awvalid1, awaddr1}, {1'b1, hold_aw1});
                if (stall_w1)  check_val("w_hold1", {wvalid1, wdata1}, {1'b1, hold_w1});
                if (stall_ar1) check_val("ar_hold1", {arvalid1, araddr1}, {1'b1, hold_ar1});
                awready1 = 1'($urandom_range(0, 1));
                wready1  = 1'($urandom_range(0, 1));
                arready1 = 1'($urandom_range(0, 1));
                bvalid1  = bpend1;
                if (!rv1 && rleft1 > 0 && $urandom_range(0, 1) == 1) rv1 = 1'b1;
                rvalid1 = rv1;
                rdata1  = rv1 ? mem1[raddr1] : '0;
                rlast1  = rv1;
                stall_aw1 = awvalid1 && !awready1; hold_aw1 = awaddr1;
                stall_w1  = wvalid1 && !wready1;   hold_w1  = wdata1;
                stall_ar1 = arvalid1 && !arready1; hold_ar1 = araddr1;
                if (awvalid1 && awready1) begin
                    if (exp_aw1.size() == 0) check_val("aw_extra1", 1, 0);
                    else check_val("awaddr1", awaddr1, exp_aw1.pop_front());
                    check_val("aw_ctl1", {awlen1, awsize1, awburst1}, {8'd0, 3'd3, 2'd1});
                    waddr1 = awaddr1;
                end
                if (wvalid1 && wready1) begin
                    if (exp_w1.size() == 0) check_val("w_extra1", 1, 0);
                    else check_val("wdata1", wdata1, exp_w1.pop_front());
                    check_val("w_last_strb1", {wlast1, wstrb1}, {1'b1, 8'hFF});
                    mem1[waddr1] = wdata1;
                    bpend1 = 1'b1;
                end
                if (bvalid1 && bready1) bpend1 = 1'b0;
                if (arvalid1 && arready1) begin
                    if (exp_ar1.size() == 0) check_val("ar_extra1", 1, 0);
                    else check_val("araddr1", araddr1, exp_ar1.pop_front());
                    raddr1 = araddr1; rleft1 = 1;
                end
                if (rv1 && rready1) begin
                    rleft1--; rv1 = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic queue_run0();
        exp_aw0.delete(); exp_ar0.delete(); exp_w0.delete();
        aw_cnt0 = 0; ar_cnt0 = 0;
        for (int n = 0; n < 4; n++) begin
            exp_aw0.push_back(32'(n * 32));
            exp_ar0.push_back(32'(n * 32));
            for (int b = 0; b < 8; b++) exp_w0.push_back(32'(n * 8 + b + 1));
        end
    endtask

    task automatic run0(input logic bp, input logic corrupt, input logic berr,
                        input int exp_err, input logic chk_lat);
        int cyc;
        queue_run0();
        bp0 = bp; corrupt0 = corrupt; berr0 = berr;
        start0 = 1'b1;
        @(posedge clk); #2;
        start0 = 1'b0;
        check_val("run_start", {busy0, done0, err0}, {1'b1, 1'b0, 16'd0});
        cyc = 0;
        while (!done0 && cyc < 5000) begin
            start0 = (cyc == 30);   // a start while busy must be ignored
            @(posedge clk); #2;
            cyc++;
        end
        start0 = 1'b0;
        check_val("done_seen", done0, 1);
        if (chk_lat) check_val("latency", cyc, 80);
        check_val("pass", pass0, exp_err == 0);
        check_val("err_cnt", err0, exp_err);
        check_val("busy_done", busy0, 0);
        check_val("bursts", {8'(aw_cnt0), 8'(ar_cnt0)}, {8'd4, 8'd4});
        check_val("sb_empty", exp_aw0.size() + exp_ar0.size() + exp_w0.size(), 0);
    endtask

    initial begin
        int cyc;
        #2;
        check_val("rst_ctl", {awvalid0, wvalid0, arvalid0, bready0, rready0, busy0, done0, pass0}, 0);
        check_val("rst_err", err0, 0);
        check_val("rst_payload", {awaddr0, awlen0, wdata0, araddr0, arlen0}, 0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        start0 = 1'b1;              // lands on the first edge after release
        @(posedge clk); #2;
        start0 = 1'b0;
        check_val("settle_ignore", busy0, 0);

        run0(1'b0, 1'b0, 1'b0, 0, 1'b1);
        run0(1'b0, 1'b1, 1'b0, 1, 1'b1);
        run0(1'b0, 1'b0, 1'b1, 4, 1'b1);
        run0(1'b1, 1'b0, 1'b0, 0, 1'b0);

        // reset during W beat 5 of burst 2
        queue_run0();
        bp0 = 1'b0; corrupt0 = 1'b0; berr0 = 1'b0;
        start0 = 1'b1;
        @(posedge clk); #2;
        start0 = 1'b0;
        cyc = 0;
        while (!(aw_cnt0 == 3 && wbeat0 == 5) && cyc < 2000) begin
            @(posedge clk); #2;
            cyc++;
        end
        check_val("reach_b2_w5", wvalid0 && cyc < 2000, 1);
        rst = 1'b1;
        #1;
        check_val("midrst_ctl", {awvalid0, wvalid0, arvalid0, bready0, rready0, busy0, done0}, 0);
        check_val("midrst_payload", {wdata0, awaddr0, err0}, 0);
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;
        run0(1'b0, 1'b0, 1'b0, 0, 1'b1);

        // 64-bit single-beat bursts wrapping through the top of the address space
        exp_aw1.delete(); exp_ar1.delete(); exp_w1.delete();
        for (int n = 0; n < 2; n++) begin
            exp_aw1.push_back(32'hFFFF_FFF8 + 32'(n * 8));
            exp_ar1.push_back(32'hFFFF_FFF8 + 32'(n * 8));
            exp_w1.push_back(64'(n + 1));
        end
        start1 = 1'b1;
        @(posedge clk); #2;
        start1 = 1'b0;
        cyc = 0;
        while (!done1 && cyc < 2000) begin
            @(posedge clk); #2;
            cyc++;
        end
        check_val("done1", done1, 1);
        check_val("pass1", {pass1, err1}, {1'b1, 16'd0});
        check_val("sb_empty1", exp_aw1.size() + exp_ar1.size() + exp_w1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
